// File: rtl/uart_rx_frame.sv
// uart_rx_frame: configurable UART receiver (5-8 data bits, optional even/odd
// parity, 1 or 2 stop bits) with 3-sample majority voting, false-start
// rejection, break detection and a valid/ready holding register that reports
// overruns. Bit timing comes from an external oversampling baud tick.
module uart_rx_frame #(
    parameter int OSR         = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       baud_tick,
    input  logic [1:0] cfg_data_bits,
    input  logic       cfg_parity_en,
    input  logic       cfg_parity_odd,
    input  logic       cfg_stop2,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_parity_err,
    output logic       rx_frame_err,
    output logic       rx_break,
    output logic       rx_overrun,
    output logic       rx_busy
);

    localparam int CNT_W = $clog2(OSR);
    localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(OSR / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(OSR / 2);
    localparam logic [CNT_W-1:0] CNT_S2   = CNT_W'(OSR / 2 + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OSR - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRK_WAIT
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    logic [CNT_W-1:0]       sample_cnt;
    logic                   samp0_q, samp1_q;
    logic                   maj;
    logic                   decide, bit_end;

    // Per-frame configuration, frozen at the start-bit decision
    logic [1:0] bits_q;
    logic       par_en_q, par_odd_q, stop2_q;

    logic [7:0] data_q;
    logic [3:0] bit_idx;
    logic [3:0] n_bits;
    logic       pbit_q, perr_q, ferr_q, stop_idx_q;
    logic       last_stop;

    logic       frame_done, final_ferr, final_brk;

    assign rxs       = sync_q[SYNC_STAGES-1];
    assign decide    = baud_tick && (sample_cnt == CNT_S2);
    assign bit_end   = baud_tick && (sample_cnt == CNT_LAST);
    assign maj       = (samp0_q & samp1_q) | (samp0_q & rxs) | (samp1_q & rxs);
    assign n_bits    = 4'd5 + {2'b00, bits_q};
    assign last_stop = !stop2_q || stop_idx_q;

    // Bring the asynchronous line into the clk domain; idles high out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
        end
    end

    // Oversample counter: held at zero while waiting, otherwise wraps each bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt <= '0;
        end else if (state_q == IDLE || state_q == BRK_WAIT) begin
            sample_cnt <= '0;
        end else if (baud_tick) begin
            sample_cnt <= (sample_cnt == CNT_LAST) ? '0 : sample_cnt + CNT_W'(1);
        end
    end

    // Capture the first two of the three mid-bit samples; the third is live rxs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp0_q <= 1'b0;
            samp1_q <= 1'b0;
        end else begin
            if (baud_tick && sample_cnt == CNT_S0) samp0_q <= rxs;
            if (baud_tick && sample_cnt == CNT_S1) samp1_q <= rxs;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: everything but the start-edge detect waits for a tick
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!rxs) state_d = START;
            end
            START: begin
                if (decide && maj)  state_d = IDLE;
                else if (bit_end)   state_d = DATA;
            end
            DATA: begin
                if (bit_end && bit_idx == n_bits)
                    state_d = par_en_q ? PARITY : STOP;
            end
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                if (decide && last_stop)
                    state_d = (ferr_q || !maj) ? BRK_WAIT : IDLE;
            end
            BRK_WAIT: begin
                if (baud_tick && rxs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: frame completion strobe and the final status of that frame
    always_comb begin
        frame_done = 1'b0;
        final_ferr = ferr_q | ~maj;
        final_brk  = final_ferr && (data_q == 8'h00) && (!par_en_q || !pbit_q);
        if (state_q == STOP && decide && last_stop) frame_done = 1'b1;
    end

    // Frame datapath: latch config, assemble data bits, evaluate parity and stop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bits_q     <= 2'd0;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            stop2_q    <= 1'b0;
            data_q     <= 8'h00;
            bit_idx    <= 4'd0;
            pbit_q     <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            stop_idx_q <= 1'b0;
        end else begin
            if (state_q == START && decide && !maj) begin
                bits_q     <= cfg_data_bits;
                par_en_q   <= cfg_parity_en;
                par_odd_q  <= cfg_parity_odd;
                stop2_q    <= cfg_stop2;
                data_q     <= 8'h00;
                bit_idx    <= 4'd0;
                pbit_q     <= 1'b0;
                perr_q     <= 1'b0;
                ferr_q     <= 1'b0;
                stop_idx_q <= 1'b0;
            end
            if (state_q == DATA && decide) begin
                data_q[bit_idx[2:0]] <= maj;
                bit_idx              <= bit_idx + 4'd1;
            end
            if (state_q == PARITY && decide) begin
                pbit_q <= maj;
                perr_q <= ((^data_q) ^ maj) != par_odd_q;
            end
            if (state_q == STOP && decide) begin
                if (!maj) ferr_q <= 1'b1;
                stop_idx_q <= 1'b1;
            end
        end
    end

    // Holding register: load on completion unless full and not being drained
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data       <= 8'h00;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_break      <= 1'b0;
            rx_overrun    <= 1'b0;
        end else begin
            rx_overrun <= 1'b0;
            if (frame_done) begin
                if (!rx_valid || rx_ready) begin
                    rx_valid      <= 1'b1;
                    rx_data       <= data_q;
                    rx_parity_err <= perr_q;
                    rx_frame_err  <= final_ferr;
                    rx_break      <= final_brk;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    // Busy flag follows the FSM one clock late
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_busy <= 1'b0;
        end else begin
            rx_busy <= (state_q != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed bench for uart_rx_frame. A table of frame
// formats is serialised onto rx and the delivered frames are compared with
// hand-computed values; glitch, break, overrun and reset cases are written
// out as explicit sequences.
module tb_uart_rx_frame;

    localparam int OSR = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       baud_tick = 1'b0;
    logic [1:0] cfg_data_bits = 2'd0;
    logic       cfg_parity_en = 1'b0;
    logic       cfg_parity_odd = 1'b0;
    logic       cfg_stop2 = 1'b0;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, rx_parity_err, rx_frame_err, rx_break, rx_overrun, rx_busy;

    int checks = 0;
    int errors = 0;
    int tick_div = 0;
    int overrun_cnt = 0;
    int rd_idx = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
    } frame_t;

    typedef struct {
        logic [1:0] bits;
        logic       par_en;
        logic       par_odd;
        logic       stop2;
        logic [7:0] data;
        logic       flip_par;
        logic [1:0] stop_low;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
        logic       exp_brk;
    } vec_t;

    frame_t cap[$];
    vec_t   vecs[12];

    uart_rx_frame #(.OSR(OSR), .SYNC_STAGES(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx            (rx),
        .baud_tick     (baud_tick),
        .cfg_data_bits (cfg_data_bits),
        .cfg_parity_en (cfg_parity_en),
        .cfg_parity_odd(cfg_parity_odd),
        .cfg_stop2     (cfg_stop2),
        .rx_ready      (rx_ready),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_parity_err (rx_parity_err),
        .rx_frame_err  (rx_frame_err),
        .rx_break      (rx_break),
        .rx_overrun    (rx_overrun),
        .rx_busy       (rx_busy)
    );

    // 100 MHz system clock
    always #5 clk = ~clk;

    // Baud tick every fourth clock, changed on the falling edge
    always @(negedge clk) begin
        tick_div  = (tick_div == 3) ? 0 : tick_div + 1;
        baud_tick = (tick_div == 0);
    end

    // Record every transferred frame and every overrun pulse
    always @(negedge clk) begin
        frame_t f;
        if (rx_valid && rx_ready) begin
            f.data = rx_data;
            f.perr = rx_parity_err;
            f.ferr = rx_frame_err;
            f.brk  = rx_break;
            cap.push_back(f);
        end
        if (rx_overrun) overrun_cnt++;
    end

    // Runaway guard
    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mkVec(input logic [1:0] bits, input logic pe, input logic po,
                                   input logic s2, input logic [7:0] data, input logic flip,
                                   input logic [1:0] sl, input logic [7:0] ed,
                                   input logic ep, input logic ef, input logic eb);
        vec_t v;
        v.bits = bits;   v.par_en = pe;   v.par_odd = po;  v.stop2 = s2;
        v.data = data;   v.flip_par = flip; v.stop_low = sl;
        v.exp_data = ed; v.exp_perr = ep; v.exp_ferr = ef; v.exp_brk = eb;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic waitTicks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (!baud_tick) @(posedge clk);
        end
        #1;
    endtask

    task automatic sendBit(input logic b);
        rx = b;
        waitTicks(OSR);
    endtask

    // Serialise one frame; config is scrambled after the start bit
    task automatic applyStimulus(input vec_t v);
        logic [7:0] sh;
        logic       pbit;
        int         nb;
        nb             = 5 + int'(v.bits);
        cfg_data_bits  = v.bits;
        cfg_parity_en  = v.par_en;
        cfg_parity_odd = v.par_odd;
        cfg_stop2      = v.stop2;
        sendBit(1'b0);
        cfg_data_bits  = ~v.bits;
        cfg_parity_en  = ~v.par_en;
        cfg_parity_odd = ~v.par_odd;
        cfg_stop2      = ~v.stop2;
        sh = v.data;
        for (int i = 0; i < nb; i++) begin
            sendBit(sh[0]);
            sh = sh >> 1;
        end
        if (v.par_en) begin
            pbit = (^v.data) ^ v.par_odd ^ v.flip_par;
            sendBit(pbit);
        end
        sendBit(~v.stop_low[0]);
        if (v.stop2) sendBit(~v.stop_low[1]);
        sendBit(1'b1);
        sendBit(1'b1);
    endtask

    task automatic expectFrame(input string name, input logic [7:0] d,
                               input logic pe, input logic fe, input logic br);
        int     avail;
        frame_t f;
        avail = cap.size() - rd_idx;
        checkOutput({name, "_count"}, avail, 1);
        if (avail > 0) begin
            f = cap[rd_idx];
            checkOutput({name, "_data"}, f.data, d);
            checkOutput({name, "_perr"}, f.perr, pe);
            checkOutput({name, "_ferr"}, f.ferr, fe);
            checkOutput({name, "_brk"},  f.brk,  br);
            rd_idx = cap.size();
        end
    endtask

    initial begin
        vec_t       v;
        logic [7:0] d;
        int         ov_base;

        //                 bits   pe    po    s2    data   flip  stoplow  exp    perr  ferr  brk
        vecs[0]  = mkVec(2'd3, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 2'b00, 8'hA5, 1'b0, 1'b0, 1'b0);
        vecs[1]  = mkVec(2'd2, 1'b1, 1'b0, 1'b1, 8'h35, 1'b1, 2'b00, 8'h35, 1'b1, 1'b0, 1'b0);
        vecs[2]  = mkVec(2'd0, 1'b1, 1'b1, 1'b0, 8'h1F, 1'b0, 2'b00, 8'h1F, 1'b0, 1'b0, 1'b0);
        vecs[3]  = mkVec(2'd1, 1'b1, 1'b0, 1'b0, 8'h2A, 1'b0, 2'b00, 8'h2A, 1'b0, 1'b0, 1'b0);
        vecs[4]  = mkVec(2'd3, 1'b1, 1'b1, 1'b1, 8'h80, 1'b1, 2'b00, 8'h80, 1'b1, 1'b0, 1'b0);
        vecs[5]  = mkVec(2'd3, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 2'b01, 8'h3C, 1'b0, 1'b1, 1'b0);
        vecs[6]  = mkVec(2'd0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 2'b01, 8'h00, 1'b0, 1'b1, 1'b1);
        vecs[7]  = mkVec(2'd1, 1'b0, 1'b0, 1'b0, 8'h3F, 1'b0, 2'b00, 8'h3F, 1'b0, 1'b0, 1'b0);
        vecs[8]  = mkVec(2'd3, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 2'b01, 8'h00, 1'b0, 1'b1, 1'b1);
        vecs[9]  = mkVec(2'd3, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 2'b01, 8'h00, 1'b1, 1'b1, 1'b0);
        vecs[10] = mkVec(2'd2, 1'b0, 1'b0, 1'b1, 8'h7F, 1'b0, 2'b10, 8'h7F, 1'b0, 1'b1, 1'b0);
        vecs[11] = mkVec(2'd2, 1'b1, 1'b1, 1'b1, 8'h55, 1'b0, 2'b00, 8'h55, 1'b0, 1'b0, 1'b0);

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_valid",   rx_valid, 0);
        checkOutput("reset_busy",    rx_busy, 0);
        checkOutput("reset_overrun", rx_overrun, 0);
        checkOutput("reset_data",    rx_data, 0);
        checkOutput("reset_flags",   {rx_parity_err, rx_frame_err, rx_break}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        waitTicks(20);

        // Table of frame formats with rx_ready tied high
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i]);
            expectFrame($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_perr,
                        vecs[i].exp_ferr, vecs[i].exp_brk);
            checkOutput($sformatf("vec%0d_valid_pulse", i), rx_valid, 0);
            checkOutput($sformatf("vec%0d_busy_idle", i), rx_busy, 0);
        end

        // Short low glitch on an idle line is rejected by the start check
        rx = 1'b0;
        waitTicks(4);
        checkOutput("glitch_busy_start", rx_busy, 1);
        rx = 1'b1;
        waitTicks(2 * OSR);
        checkOutput("glitch_busy_clear", rx_busy, 0);
        checkOutput("glitch_no_frame", cap.size() - rd_idx, 0);

        // Break: zero data, low stop, then line held low for three frames
        cfg_data_bits = 2'd3; cfg_parity_en = 1'b0; cfg_stop2 = 1'b0;
        sendBit(1'b0);
        for (int i = 0; i < 8; i++) sendBit(1'b0);
        sendBit(1'b0);
        rx = 1'b0;
        waitTicks(30 * OSR);
        expectFrame("break", 8'h00, 1'b0, 1'b1, 1'b1);
        checkOutput("break_busy_hold", rx_busy, 1);
        rx = 1'b1;
        waitTicks(2 * OSR);
        checkOutput("break_busy_release", rx_busy, 0);
        checkOutput("break_no_extra", cap.size() - rd_idx, 0);
        v = mkVec(2'd3, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 2'b00, 8'h5A, 1'b0, 1'b0, 1'b0);
        applyStimulus(v);
        expectFrame("after_break", 8'h5A, 1'b0, 1'b0, 1'b0);

        // Overrun: second frame arrives while the first is still held
        rx_ready = 1'b0;
        ov_base  = overrun_cnt;
        v = mkVec(2'd3, 1'b0, 1'b0, 1'b0, 8'h11, 1'b0, 2'b00, 8'h11, 1'b0, 1'b0, 1'b0);
        applyStimulus(v);
        v = mkVec(2'd3, 1'b0, 1'b0, 1'b0, 8'h22, 1'b0, 2'b00, 8'h22, 1'b0, 1'b0, 1'b0);
        applyStimulus(v);
        checkOutput("ovr_pulses", overrun_cnt - ov_base, 1);
        checkOutput("ovr_valid_held", rx_valid, 1);
        checkOutput("ovr_data_held", rx_data, 8'h11);
        rx_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("ovr_valid_fall", rx_valid, 0);
        waitTicks(OSR);
        expectFrame("ovr_read", 8'h11, 1'b0, 1'b0, 1'b0);

        // One-tick low glitch on the centre sample of a 1 data bit
        rx_ready = 1'b0;
        d = 8'hA5;
        cfg_data_bits = 2'd3; cfg_parity_en = 1'b0; cfg_stop2 = 1'b0;
        sendBit(1'b0);
        rx = 1'b1;
        waitTicks(OSR / 2);
        rx = 1'b0;
        waitTicks(1);
        rx = 1'b1;
        waitTicks(OSR / 2 - 1);
        for (int i = 1; i < 8; i++) begin
            d = d >> 1;
            sendBit(d[0]);
        end
        sendBit(1'b1);
        sendBit(1'b1);
        checkOutput("vote_valid", rx_valid, 1);
        checkOutput("vote_data", rx_data, 8'hA5);
        checkOutput("vote_flags", {rx_parity_err, rx_frame_err, rx_break}, 0);

        // Reset in the middle of DATA drops the partial and the held frame
        sendBit(1'b0);
        sendBit(1'b0);
        sendBit(1'b1);
        sendBit(1'b0);
        checkOutput("rst_pre_busy", rx_busy, 1);
        rst_n = 1'b0;
        rx    = 1'b1;
        #2;
        checkOutput("rst_mid_valid", rx_valid, 0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_mid_busy",    rx_busy, 0);
        checkOutput("rst_mid_data",    rx_data, 0);
        checkOutput("rst_mid_flags",   {rx_parity_err, rx_frame_err, rx_break}, 0);
        checkOutput("rst_mid_overrun", rx_overrun, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        rd_idx = cap.size();
        rx_ready = 1'b1;
        waitTicks(2 * OSR);
        v = mkVec(2'd3, 1'b0, 1'b0, 1'b0, 8'hC3, 1'b0, 2'b00, 8'hC3, 1'b0, 1'b0, 1'b0);
        applyStimulus(v);
        expectFrame("after_reset", 8'hC3, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
